// File: rtl/prog_mem_loader.sv
// Purpose : 64x6 program memory. An external loader fills it while the CPU is
//           held in reset, then the CPU is released and fetches from it.
// Latency : writes land on the accepting clk edge; in RUN the read is
//           combinational (rdata follows addr in the same cycle).
// Backpressure: prog_ready is high only in LOAD; words offered in HOLD/RUN
//           are dropped. prog_start always wins over prog_valid.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   addr       - CPU fetch address (never changes state)
//   rdata      - CPU fetch data, zero outside RUN
//   prog_start - one-cycle pulse, restarts a load from address 0
//   prog_valid - prog_data carries a word
//   prog_data  - program word
//   prog_last  - marks the final word of a load
//   prog_ready - high while words are accepted (LOAD)
//   cpu_reset  - registered, active-high CPU reset, low only in RUN
//   load_count - words written in the current/most recent load (0..64)
//   state_o    - 0 = LOAD, 1 = HOLD, 2 = RUN

module prog_mem_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] addr,
   output logic [5:0] rdata,
   input  logic       prog_start,
   input  logic       prog_valid,
   input  logic [5:0] prog_data,
   input  logic       prog_last,
   output logic       prog_ready,
   output logic       cpu_reset,
   output logic [6:0] load_count,
   output logic [1:0] state_o
);

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [5:0]       wr_ptr;
   logic [6:0]       load_cnt;
   logic             hold_cnt;
   logic [63:0][5:0] mem;

   logic             wr_en;
   logic             wr_done;

   // prog_start suppresses the write even when prog_valid is high.
   assign wr_en   = (state == ST_LOAD) && prog_valid && !prog_start;
   // Writing address 63 closes the load, so load_cnt tops out at 64.
   assign wr_done = wr_en && (prog_last || (wr_ptr == 6'd63));

   always_comb begin
      state_nxt = state;
      if (prog_start) begin
         state_nxt = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: if (wr_done)  state_nxt = ST_HOLD;
            ST_HOLD: if (hold_cnt) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_LOAD;
         hold_cnt  <= 1'b0;
         cpu_reset <= 1'b1;
         wr_ptr    <= 6'd0;
         load_cnt  <= 7'd0;
      end else begin
         state     <= state_nxt;
         // hold_cnt is 0 on the first HOLD cycle and 1 on the second, so
         // HOLD spans exactly two cycles before RUN.
         hold_cnt  <= (state == ST_HOLD) && (state_nxt == ST_HOLD);
         cpu_reset <= (state_nxt != ST_RUN);
         if (prog_start) begin
            wr_ptr   <= 6'd0;
            load_cnt <= 7'd0;
         end else if (wr_en) begin
            wr_ptr   <= wr_ptr + 6'd1;
            load_cnt <= load_cnt + 7'd1;
         end
      end
   end

   // The whole array is cleared by reset so an aborted load leaves nothing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem <= '0;
      end else if (wr_en) begin
         mem[wr_ptr] <= prog_data;
      end
   end

   assign rdata      = (state == ST_RUN) ? mem[addr] : 6'd0;
   assign prog_ready = (state == ST_LOAD);
   assign load_count = load_cnt;
   assign state_o    = state;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed load/run/reload/reset scenarios
// followed by random traffic, checked against a behavioural model.
module tb_prog_mem_loader;

   logic       clk;
   logic       reset;
   logic [5:0] addr;
   logic [5:0] rdata;
   logic       prog_start;
   logic       prog_valid;
   logic [5:0] prog_data;
   logic       prog_last;
   logic       prog_ready;
   logic       cpu_reset;
   logic [6:0] load_count;
   logic [1:0] state_o;

   prog_mem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .rdata      (rdata),
      .prog_start (prog_start),
      .prog_valid (prog_valid),
      .prog_data  (prog_data),
      .prog_last  (prog_last),
      .prog_ready (prog_ready),
      .cpu_reset  (cpu_reset),
      .load_count (load_count),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference model: phase 0 = loading, 1 = holding, 2 = running.
   int m_mem [64];
   int m_phase;
   int m_ptr;
   int m_cnt;
   int m_hold_edges;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_mem[i] = 0;
      m_phase      = 0;
      m_ptr        = 0;
      m_cnt        = 0;
      m_hold_edges = 0;
   endtask

   task automatic model_edge(input bit st, input bit vl, input int d, input bit ls);
      if (st) begin
         m_phase = 0;
         m_ptr   = 0;
         m_cnt   = 0;
      end else if (m_phase == 0) begin
         if (vl) begin
            m_mem[m_ptr] = d;
            m_cnt++;
            if (ls || m_ptr == 63) begin
               m_phase      = 1;
               m_hold_edges = 0;
            end
            m_ptr = (m_ptr + 1) % 64;
         end
      end else if (m_phase == 1) begin
         m_hold_edges++;
         if (m_hold_edges == 2) m_phase = 2;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"},  int'(state_o),    m_phase);
      chk({tag, ".ready"},  int'(prog_ready), (m_phase == 0) ? 1 : 0);
      chk({tag, ".cpurst"}, int'(cpu_reset),  (m_phase == 2) ? 0 : 1);
      chk({tag, ".count"},  int'(load_count), m_cnt);
      chk({tag, ".rdata"},  int'(rdata),      (m_phase == 2) ? m_mem[int'(addr)] : 0);
   endtask

   // One clock: apply inputs, step model, sample 1 time unit after the edge.
   task automatic drive(input bit st, input bit vl, input int d, input bit ls,
                        input int a, input string tag);
      prog_start = st;
      prog_valid = vl;
      prog_data  = 6'(d);
      prog_last  = ls;
      addr       = 6'(a);
      model_edge(st, vl, d, ls);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, tag);
   endtask

   task automatic peek(input int a, input int exp, input string tag);
      addr = 6'(a);
      #1;
      chk(tag, int'(rdata), exp);
   endtask

   int edges;

   initial begin
      reset      = 1'b0;
      addr       = '0;
      prog_start = 1'b0;
      prog_valid = 1'b0;
      prog_data  = '0;
      prog_last  = 1'b0;
      model_reset();
      #12;
      check_all("rst");
      @(negedge clk);
      reset = 1'b1;

      // Basic load of 1,2,3 then run.
      drive(0, 1, 1, 0, 0, "b.w0");
      drive(0, 1, 2, 0, 0, "b.w1");
      drive(0, 1, 3, 1, 0, "b.w2");
      chk("b.count3", int'(load_count), 3);
      chk("b.hold",   int'(state_o), 1);
      idle(2, "b.hold");
      chk("b.run",    int'(state_o), 2);
      chk("b.cpurst", int'(cpu_reset), 0);
      peek(0, 1, "b.rd0");
      peek(1, 2, "b.rd1");
      peek(2, 3, "b.rd2");
      peek(3, 0, "b.rd3");

      // Full 64-word load without prog_last.
      drive(1, 0, 0, 0, 0, "f.start");
      for (int i = 0; i < 64; i++) drive(0, 1, i % 64, 0, 0, "f.w");
      chk("f.hold",    int'(state_o), 1);
      chk("f.count64", int'(load_count), 64);
      drive(0, 1, 55, 0, 0, "f.ignored");
      chk("f.count64b", int'(load_count), 64);
      idle(1, "f.hold");
      chk("f.run", int'(state_o), 2);
      peek(63, 63, "f.rd63");
      peek(0, 0, "f.rd0");

      // prog_start beats prog_valid at wr_ptr = 5.
      drive(1, 0, 0, 0, 0, "p.start");
      for (int i = 0; i < 5; i++) drive(0, 1, 20 + i, 0, 0, "p.w");
      drive(1, 1, 7, 0, 0, "p.both");
      chk("p.count0", int'(load_count), 0);
      drive(0, 1, 30, 1, 0, "p.w0");
      chk("p.count1", int'(load_count), 1);
      idle(2, "p.hold");
      peek(0, 30, "p.rd0");
      peek(5, 5, "p.rd5");
      peek(2, 22, "p.rd2");

      // Reload from RUN, also measuring edges from last write to CPU release.
      drive(1, 0, 0, 0, 3, "r.start");
      chk("r.cpurst", int'(cpu_reset), 1);
      chk("r.rdata0", int'(rdata), 0);
      drive(0, 1, 9, 0, 0, "r.w0");
      drive(0, 1, 10, 1, 0, "r.w1");
      edges = 1;
      while (cpu_reset && edges < 10) begin
         idle(1, "r.wait");
         edges++;
      end
      chk("h.edges3", edges, 3);
      peek(0, 9, "r.rd0");
      peek(1, 10, "r.rd1");
      peek(2, 22, "r.rd2");

      // Asynchronous reset between edges while running.
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("a.state",  int'(state_o), 0);
      chk("a.cpurst", int'(cpu_reset), 1);
      chk("a.rdata",  int'(rdata), 0);
      chk("a.count",  int'(load_count), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      peek(0, 0, "a.rd0");
      peek(1, 0, "a.rd1");
      idle(3, "a.idle");
      drive(0, 1, 4, 1, 0, "a.w0");
      idle(2, "a.hold");
      peek(0, 4, "a.rdnew");
      peek(1, 0, "a.rdcleared");

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom % 40) == 0, ($urandom % 3) != 0, int'($urandom % 64),
               ($urandom % 8) == 0, int'($urandom % 64), "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 = in reset.
- addr  input  6  fetch address, driven from the CPU's mem_request.
- rdata  output  6  fetch data, driving the CPU's mem_in.
- prog_start  input  1  one-cycle pulse; begins a new program load.
- prog_valid  input  1  prog_data holds a word to write.
- prog_data  input  6  program word.
- prog_last  input  1  qualifies prog_data as the final word of the load.
- prog_ready  output  1  block accepts a word on this cycle.
- cpu_reset  output  1  active-high synchronous reset for the CPU.
- load_count  output  7  number of words written in the current or most recent load (0-64).
- state_o  output  2  current state encoding: 0 = LOAD, 1 = HOLD, 2 = RUN.

Function
REQ-002 Storage SHALL be 64 words x 6 bits, indexed by a 6-bit address.
REQ-003 The FSM SHALL have three states: LOAD, HOLD and RUN.
- After reset the state SHALL be LOAD.
- Encoding 3 SHALL never occur.
REQ-004 prog_ready SHALL be 1 in LOAD and 0 in HOLD and RUN; it is combinational from the state only.
REQ-005 A write occurs on a rising edge when state = LOAD, prog_valid = 1 and prog_start = 0:
- mem[wr_ptr] <= prog_data;
- wr_ptr <= wr_ptr + 1 (6-bit, wraps 63 -> 0);
- load_count <= load_count + 1.
REQ-006 A write with prog_last = 1, or a write at wr_ptr = 63, SHALL move the state LOAD -> HOLD on the same edge.
- Hence load_count saturates at 64 and never wraps.
REQ-007 HOLD SHALL last exactly 2 clock cycles, then move to RUN.
REQ-008 cpu_reset SHALL be registered and equal 1 in every state except RUN.
- On the edge entering RUN it SHALL go to 0.
REQ-009 A prog_start = 1 in any state SHALL, on that edge:
- move the state to LOAD;
- clear wr_ptr and load_count to 0;
- set cpu_reset to 1;
- not perform any write that cycle (prog_start has priority over prog_valid).
REQ-010 In RUN, rdata SHALL equal mem[addr] combinationally (zero-cycle read).
- This lets the CPU capture data one cycle after presenting the address.
REQ-011 In LOAD and HOLD, rdata SHALL be 6'b000000.
REQ-012 Words not written during a load SHALL retain their prior contents.
REQ-013 prog_valid and prog_data SHALL be ignored outside LOAD.
- prog_last SHALL be ignored unless a write occurs.
REQ-014 addr SHALL never modify any state.

Reset
REQ-015 While reset = 0, the following SHALL hold asynchronously:
- state = LOAD;
- wr_ptr = 0 and load_count = 0;
- all 64 memory words = 0;
- cpu_reset = 1 and rdata = 0.
REQ-016 Release of reset SHALL be treated as synchronous to clk; the first write is possible on the first rising edge after release.
REQ-017 Assertion of reset mid-load or in RUN SHALL abort all activity immediately.
- No partial write survives: memory is cleared per REQ-015.

Verification
REQ-018 Basic load and run: after reset, write words 1, 2, 3 with prog_last on the third word.
- load_count = 3.
- HOLD for 2 cycles, then RUN with cpu_reset = 0.
- addr = 0, 1, 2, 3 -> rdata = 1, 2, 3, 0.
REQ-019 Full load: write 64 words with values i mod 64 and no prog_last.
- After word 63 the state is HOLD and load_count = 64.
- The next prog_valid is ignored.
- In RUN, addr = 63 -> rdata = 63.
REQ-020 Priority: in LOAD at wr_ptr = 5, assert prog_start and prog_valid together with data 7.
- No write occurs; wr_ptr = 0 and load_count = 0.
- mem[5] is unchanged.
REQ-021 Reload from RUN: pulse prog_start.
- cpu_reset = 1 on the next edge and rdata = 0.
- Load 2 words 9, 10 with prog_last.
- In RUN, mem[0..1] = 9, 10 and mem[2] keeps its earlier value.
REQ-022 Async reset: drop reset between edges while in RUN.
- cpu_reset = 1, rdata = 0 and state_o = 0 immediately, without waiting for a clock edge.
- After release, any addr -> rdata = 0 until a new load completes.
REQ-023 HOLD timing: count edges from the prog_last write to cpu_reset falling.
- The count SHALL be exactly 3 (entry into HOLD, 2 HOLD cycles, then RUN).
